// File: rtl/usb_rx_phy_pkg.sv
// Shared types for the low-speed USB receive path.
// d_port_t carries the raw {dp, dm} pair; J, K, SE0 and SE1 name the four
// low-speed line states. SYNC_PATTERN is the SYNC field as it appears after
// eight LSB-first shifts. SE0_RESET_SAMPLES is the number of consecutive SE0
// samples (more than four bit times) treated as a bus reset.
package types;
    typedef logic [1:0] d_port_t;   // {dp, dm}

    localparam d_port_t J   = 2'b01;
    localparam d_port_t K   = 2'b10;
    localparam d_port_t SE0 = 2'b00;
    localparam d_port_t SE1 = 2'b11;

    localparam logic [7:0] SYNC_PATTERN      = 8'h80;
    localparam int         SE0_RESET_SAMPLES = 5;
    localparam int         ABORT_J_SAMPLES   = 8;
endpackage

// File: rtl/usb_rx_phy_if.sv
// Byte stream from the receive PHY to the packet logic.
//   rx_data   received byte, LSB first on the wire
//   rx_valid  one-cycle strobe, rx_data valid
//   rx_active high from SYNC detect to end of packet
//   rx_error  one-cycle strobe, packet aborted
//   rx_eop    one-cycle strobe, clean end of packet
// master: the PHY (drives), slave: the consumer.
interface usb_rx_phy_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;
    logic       rx_eop;

    modport master (output rx_data, rx_valid, rx_active, rx_error, rx_eop);
    modport slave  (input  rx_data, rx_valid, rx_active, rx_error, rx_eop);
endinterface

// File: rtl/usb_rx_dpll.sv
// Line front end: two-flop synchroniser, edge detect and phase counter.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   d_i         raw {dp, dm}, asynchronous to clk
//   sample      one-cycle strobe near the middle of each bit cell
//   line        synchronised line state to use at the strobe
// The phase counter restarts whenever the line moves into J or K, so the
// strobe lands CLKS_PER_BIT/2 clocks after every data edge.
module usb_rx_dpll
    import types::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  d_port_t d_i,
    output logic    sample,
    output d_port_t line
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_MID = PW'(CLKS_PER_BIT / 2);

    d_port_t         sync1_reg;
    d_port_t         sync2_reg;
    d_port_t         prev_reg;
    logic [PW-1:0]   phase_reg;
    logic            edge_det;

    // Transitions into SE0/SE1 do not carry timing; only J/K edges resync.
    assign edge_det = (sync2_reg != prev_reg) && ((sync2_reg == J) || (sync2_reg == K));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= J;
            sync2_reg <= J;
            prev_reg  <= J;
            phase_reg <= '0;
        end else begin
            sync1_reg <= d_i;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (edge_det || (phase_reg == PHASE_MAX)) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

    // prev_reg takes the new line value on the same edge the counter clears,
    // so it is the value that belongs to the current phase.
    assign sample = (phase_reg == PHASE_MID);
    assign line   = prev_reg;
endmodule

// File: rtl/usb_rx_phy.sv
// Low-speed USB receive PHY: NRZI decode, bit unstuffing, SYNC/EOP detection
// and byte assembly on top of the DPLL sample strobe.
// Ports:
//   clk, reset  system clock (24 MHz), synchronous active-high reset
//   d_i         raw {dp, dm} line pair
//   rx          byte stream out (usb_rx_phy_if.master)
module usb_rx_phy
    import types::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  d_port_t d_i,
    usb_rx_phy_if.master rx
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

    logic    sample;
    d_port_t line;

    usb_rx_dpll #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dpll (
        .clk    (clk),
        .reset  (reset),
        .d_i    (d_i),
        .sample (sample),
        .line   (line)
    );

    state_t     state_reg,   state_next;
    d_port_t    prev_reg,    prev_next;     // line at the previous strobe
    logic [2:0] ones_reg,    ones_next;     // run of decoded 1s
    logic [2:0] bit_reg,     bit_next;      // bit position in SYNC / byte
    logic [7:0] shift_reg,   shift_next;
    logic [3:0] j_cnt_reg,   j_cnt_next;    // consecutive J samples in ABORT
    logic [2:0] se0_cnt_reg, se0_cnt_next;  // consecutive SE0 samples
    logic [7:0] data_reg,    data_next;
    logic       valid_reg,   valid_next;
    logic       active_reg,  active_next;
    logic       error_reg,   error_next;
    logic       eop_reg,     eop_next;

    logic       nrzi_bit;
    logic [7:0] shifted;
    logic       fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prev_reg    <= J;
            ones_reg    <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            j_cnt_reg   <= '0;
            se0_cnt_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            active_reg  <= 1'b0;
            error_reg   <= 1'b0;
            eop_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            prev_reg    <= prev_next;
            ones_reg    <= ones_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            j_cnt_reg   <= j_cnt_next;
            se0_cnt_reg <= se0_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            active_reg  <= active_next;
            error_reg   <= error_next;
            eop_reg     <= eop_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        prev_next    = prev_reg;
        ones_next    = ones_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        j_cnt_next   = j_cnt_reg;
        se0_cnt_next = se0_cnt_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        active_next  = active_reg;
        error_next   = 1'b0;
        eop_next     = 1'b0;
        fault        = 1'b0;
        nrzi_bit     = (line == prev_reg);
        shifted      = {nrzi_bit, shift_reg[7:1]};

        if (sample) begin
            prev_next = line;
            if (line == SE0) begin
                if (se0_cnt_reg != 3'b111) se0_cnt_next = se0_cnt_reg + 3'd1;
            end else begin
                se0_cnt_next = '0;
            end

            case (state_reg)
                IDLE: begin
                    ones_next = '0;
                    bit_next  = '0;
                    // The K that leaves idle is already SYNC bit 0 (a 0).
                    if (line == K) begin
                        state_next = SYNC;
                        bit_next   = 3'd1;
                        shift_next = '0;
                    end
                end
                SYNC: begin
                    if ((line == SE0) || (line == SE1)) begin
                        state_next = IDLE;
                    end else begin
                        shift_next = shifted;
                        bit_next   = bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
                            if (shifted == SYNC_PATTERN) begin
                                state_next  = DATA;
                                active_next = 1'b1;
                                // SYNC ends in a 1, which starts the stuffing run.
                                ones_next   = 3'd1;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
                DATA: begin
                    if (line == SE1) begin
                        fault = 1'b1;
                    end else if (line == SE0) begin
                        if (bit_reg == 3'd0) state_next = EOP;
                        else                 fault = 1'b1;
                    end else if (ones_reg == 3'd6) begin
                        // Stuffed bit: must be 0 and is dropped.
                        if (nrzi_bit) fault = 1'b1;
                        else          ones_next = '0;
                    end else begin
                        ones_next  = nrzi_bit ? ones_reg + 3'd1 : 3'd0;
                        shift_next = shifted;
                        bit_next   = bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
                            valid_next = 1'b1;
                            data_next  = shifted;
                        end
                    end
                end
                EOP: begin
                    if (line == J) begin
                        eop_next    = 1'b1;
                        active_next = 1'b0;
                        state_next  = IDLE;
                    end else if (line != SE0) begin
                        fault = 1'b1;
                    end
                end
                ABORT: begin
                    if (line == J) begin
                        j_cnt_next = j_cnt_reg + 4'd1;
                        if ((prev_reg == SE0) || (j_cnt_reg == 4'(ABORT_J_SAMPLES - 1))) begin
                            state_next = IDLE;
                        end
                    end else begin
                        j_cnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (fault) begin
                error_next  = 1'b1;
                active_next = 1'b0;
                j_cnt_next  = '0;
                state_next  = ABORT;
            end

            // Long SE0 is a bus reset: close any open packet as an abort.
            if ((line == SE0) && (se0_cnt_reg >= 3'(SE0_RESET_SAMPLES - 1))) begin
                state_next = IDLE;
                if (active_reg) begin
                    error_next  = 1'b1;
                    active_next = 1'b0;
                end
            end
        end
    end

    assign rx.rx_data   = data_reg;
    assign rx.rx_valid  = valid_reg;
    assign rx.rx_active = active_reg;
    assign rx.rx_error  = error_reg;
    assign rx.rx_eop    = eop_reg;
endmodule

// File: tb/tb_usb_rx_phy.sv
// Bench for usb_rx_phy: packets are encoded from bytes (SYNC, bit stuffing,
// NRZI, EOP) and driven as line symbols; received bytes and strobes are
// collected by a monitor and compared against the intended packet contents.
module tb_usb_rx_phy;
    import types::*;

    localparam int CPB = 16;

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         nextra;
        logic [7:0] extra;
        bit         stuff_en;
        int         period;
        int         exp_n;
        logic [7:0] e0;
        logic [7:0] e1;
        int         exp_eop;
        int         exp_err;
    } vec_t;

    logic    clk   = 1'b0;
    logic    reset = 1'b1;
    d_port_t d_i   = J;

    usb_rx_phy_if rx ();

    usb_rx_phy #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .d_i   (d_i),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    d_port_t    sym_q[$];
    int         eop_cnt = 0;
    int         err_cnt = 0;
    bit         active_d = 1'b0;
    bit         mask_active = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx.rx_valid) begin
            got_q.push_back(rx.rx_data);
            total++;
            if (!rx.rx_active || rx.rx_eop || rx.rx_error) begin
                bad++;
                $display("FAIL valid_flags: active=%0b eop=%0b err=%0b required 1,0,0",
                         rx.rx_active, rx.rx_eop, rx.rx_error);
            end
        end
        if (rx.rx_eop)   eop_cnt++;
        if (rx.rx_error) err_cnt++;
        if (active_d && !rx.rx_active && !mask_active) begin
            total++;
            if (!(rx.rx_eop || rx.rx_error)) begin
                bad++;
                $display("FAIL active_fall: eop=%0b err=%0b required one of them", rx.rx_eop, rx.rx_error);
            end
        end
        active_d = rx.rx_active;
    end

    function automatic d_port_t flip(input d_port_t l);
        return (l == J) ? K : J;
    endfunction

    // Wire encoding of pkt_q: SYNC, bytes LSB first, extra bits, a stuffed 0
    // after every six consecutive 1s (when enabled), NRZI from J, then SE0 SE0 J.
    task automatic build_symbols(input int nextra, input logic [7:0] extra, input bit stuff_en);
        bit      bits[$];
        d_port_t l;
        int      ones;
        bits = {};
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        foreach (pkt_q[n]) for (int i = 0; i < 8; i++) bits.push_back(pkt_q[n][i]);
        for (int i = 0; i < nextra; i++) bits.push_back(extra[i]);
        sym_q = {};
        l = J;
        ones = 0;
        foreach (bits[i]) begin
            if (bits[i]) ones++;
            else begin
                ones = 0;
                l = flip(l);
            end
            sym_q.push_back(l);
            if (stuff_en && ones == 6) begin
                l = flip(l);
                sym_q.push_back(l);
                ones = 0;
            end
        end
        sym_q.push_back(SE0);
        sym_q.push_back(SE0);
        sym_q.push_back(J);
    endtask

    task automatic run_packet(input string tag, input int nextra, input logic [7:0] extra,
                              input bit stuff_en, input int period, input int exp_eop, input int exp_err);
        got_q   = {};
        eop_cnt = 0;
        err_cnt = 0;
        build_symbols(nextra, extra, stuff_en);
        foreach (sym_q[i]) begin
            d_i = sym_q[i];
            repeat (period) @(negedge clk);
        end
        d_i = J;
        repeat (12 * CPB) @(negedge clk);
        check({tag, "_nvalid"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        check({tag, "_eop"}, eop_cnt, exp_eop);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_active_end"}, rx.rx_active, 0);
        $display("pkt %s period=%0d sent=%0d got=%0d eop=%0d err=%0d",
                 tag, period, pkt_q.size(), got_q.size(), eop_cnt, err_cnt);
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1, 8'h69, 8'h00, 0, 8'h00, 1'b1, 16, 1, 8'h69, 8'h00, 1, 0};
        vecs[1] = '{2, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 16, 2, 8'hFF, 8'h01, 1, 0};
        vecs[2] = '{1, 8'hFF, 8'h00, 0, 8'h00, 1'b0, 16, 0, 8'h00, 8'h00, 0, 1};
        vecs[3] = '{1, 8'h3C, 8'h00, 0, 8'h00, 1'b1, 16, 1, 8'h3C, 8'h00, 1, 0};
        vecs[4] = '{1, 8'hC3, 8'h00, 3, 8'h05, 1'b1, 16, 1, 8'hC3, 8'h00, 0, 1};
        vecs[5] = '{2, 8'hA5, 8'h5A, 0, 8'h00, 1'b1, 15, 2, 8'hA5, 8'h5A, 1, 0};
        vecs[6] = '{2, 8'hA5, 8'h5A, 0, 8'h00, 1'b1, 17, 2, 8'hA5, 8'h5A, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_data",   rx.rx_data,   0);
        check("rst_valid",  rx.rx_valid,  0);
        check("rst_active", rx.rx_active, 0);
        check("rst_error",  rx.rx_error,  0);
        check("rst_eop",    rx.rx_eop,    0);
        reset = 1'b0;
        repeat (4 * CPB) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            pkt_q = {};
            exp_q = {};
            pkt_q.push_back(vecs[v].b0);
            if (vecs[v].nbytes > 1) pkt_q.push_back(vecs[v].b1);
            if (vecs[v].exp_n > 0) exp_q.push_back(vecs[v].e0);
            if (vecs[v].exp_n > 1) exp_q.push_back(vecs[v].e1);
            run_packet($sformatf("vec%0d", v), vecs[v].nextra, vecs[v].extra,
                       vecs[v].stuff_en, vecs[v].period, vecs[v].exp_eop, vecs[v].exp_err);
        end

        // Reset in the middle of the first byte of a packet.
        pkt_q = '{8'h11, 8'h22};
        build_symbols(0, 8'h00, 1'b1);
        eop_cnt = 0;
        err_cnt = 0;
        got_q   = {};
        for (int i = 0; i < 14; i++) begin
            d_i = sym_q[i];
            repeat (CPB) @(negedge clk);
        end
        check("midrst_active_before", rx.rx_active, 1);
        mask_active = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_data",   rx.rx_data,   0);
        check("midrst_valid",  rx.rx_valid,  0);
        check("midrst_active", rx.rx_active, 0);
        check("midrst_error",  rx.rx_error,  0);
        check("midrst_eop",    rx.rx_eop,    0);
        reset = 1'b0;
        d_i   = J;
        repeat (12 * CPB) @(negedge clk);
        mask_active = 1'b0;
        check("midrst_no_err_pulse", err_cnt, 0);
        check("midrst_no_eop_pulse", eop_cnt, 0);
        check("midrst_no_bytes", got_q.size(), 0);
        $display("pkt midrst reset applied mid-byte");
        pkt_q = '{8'h2D};
        exp_q = '{8'h2D};
        run_packet("after_rst", 0, 8'h00, 1'b1, 16, 1, 0);

        // Random packets: every whole byte must arrive; trailing partial bits
        // turn the end of packet into an error instead of an EOP.
        for (int r = 0; r < 20; r++) begin
            int n;
            int nextra;
            int period;
            logic [7:0] extra;
            n = $urandom_range(1, 3);
            period = 15 + $urandom_range(0, 2);
            nextra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            extra  = 8'($urandom);
            pkt_q = {};
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
            exp_q = pkt_q;
            run_packet($sformatf("rnd%0d", r), nextra, extra, 1'b1, period,
                       (nextra == 0) ? 1 : 0, (nextra == 0) ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
